// File: rtl/ar_muxn_scan.sv
// N-channel registered multiplexer with manual select and timed auto-scan.
// Outputs update one cycle after the inputs are sampled; en=0 freezes them.
module ar_muxn_scan #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  input  logic                      en,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SW-1:0]             y_ch,
  output logic                      y_valid,
  output logic                      scan_wrap
);

  localparam int DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LAST_CH_I = CHANNELS - 1;
  localparam int LAST_DW_I = DWELL - 1;
  localparam int ONE_I     = 1;

  localparam logic [SW-1:0] LAST_CH = LAST_CH_I[SW-1:0];
  localparam logic [SW-1:0] CH_ONE  = ONE_I[SW-1:0];
  localparam logic [DW-1:0] LAST_DW = LAST_DW_I[DW-1:0];
  localparam logic [DW-1:0] DW_ONE  = ONE_I[DW-1:0];
  localparam logic [SW:0]   NUM_CH  = CHANNELS[SW:0];

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             was_scan_r;
  logic             was_scan_nxt_s;
  logic [SW-1:0]    ptr_r;
  logic [SW-1:0]    ptr_nxt_s;
  logic [DW-1:0]    dwell_r;
  logic [DW-1:0]    dwell_nxt_s;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] y_nxt_s;
  logic [SW-1:0]    y_ch_r;
  logic [SW-1:0]    y_ch_nxt_s;
  logic             y_valid_r;
  logic             y_valid_nxt_s;
  logic             scan_wrap_r;
  logic             scan_wrap_nxt_s;
  logic             sel_ok_s;
  logic             resume_s;
  logic             load_s;

  // One-hot style AND-OR select; an index with no matching channel yields zero.
  function automatic logic [WIDTH-1:0] chan_data(
    input logic [CHANNELS*WIDTH-1:0] bus,
    input logic [SW-1:0]             idx
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      r = (idx == k[SW-1:0]) ? bus[k*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  generate
    if ((1 << SW) == CHANNELS) begin : g_sel_full
      assign sel_ok_s = 1'b1;
    end else begin : g_sel_range
      assign sel_ok_s = ({1'b0, sel} < NUM_CH);
    end
  endgenerate

  // Operating state decode from en/mode.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (en) begin
      if (mode) begin
        state_nxt_s = ST_SCAN;
      end else begin
        state_nxt_s = ST_MANUAL;
      end
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // A pause through IDLE keeps the scan position only if scanning was the last active mode.
  assign resume_s = (state_r == ST_SCAN) || ((state_r == ST_IDLE) && was_scan_r);
  assign load_s   = (state_nxt_s == ST_SCAN) && !resume_s;

  // Next-value datapath: scan pointer, dwell timing and output selection.
  always_comb begin
    ptr_nxt_s       = ptr_r;
    dwell_nxt_s     = dwell_r;
    was_scan_nxt_s  = was_scan_r;
    y_nxt_s         = y_r;
    y_ch_nxt_s      = y_ch_r;
    y_valid_nxt_s   = y_valid_r;
    scan_wrap_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_MANUAL: begin
        was_scan_nxt_s = 1'b0;
        y_ch_nxt_s     = sel;
        if (sel_ok_s) begin
          y_nxt_s       = chan_data(a, sel);
          y_valid_nxt_s = 1'b1;
        end else begin
          y_nxt_s       = {WIDTH{1'b0}};
          y_valid_nxt_s = 1'b0;
        end
      end
      ST_SCAN: begin
        was_scan_nxt_s = 1'b1;
        if (load_s) begin
          ptr_nxt_s   = sel_ok_s ? sel : {SW{1'b0}};
          dwell_nxt_s = {DW{1'b0}};
        end else if (hold) begin
          ptr_nxt_s   = ptr_r;
          dwell_nxt_s = dwell_r;
        end else if (dwell_r == LAST_DW) begin
          dwell_nxt_s = {DW{1'b0}};
          if (ptr_r == LAST_CH) begin
            ptr_nxt_s       = {SW{1'b0}};
            scan_wrap_nxt_s = 1'b1;
          end else begin
            ptr_nxt_s       = ptr_r + CH_ONE;
            scan_wrap_nxt_s = 1'b0;
          end
        end else begin
          dwell_nxt_s = dwell_r + DW_ONE;
        end
        y_nxt_s       = chan_data(a, ptr_nxt_s);
        y_ch_nxt_s    = ptr_nxt_s;
        y_valid_nxt_s = 1'b1;
      end
      default: begin
        scan_wrap_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      was_scan_r  <= 1'b0;
      ptr_r       <= {SW{1'b0}};
      dwell_r     <= {DW{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      y_ch_r      <= {SW{1'b0}};
      y_valid_r   <= 1'b0;
      scan_wrap_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      was_scan_r  <= was_scan_nxt_s;
      ptr_r       <= ptr_nxt_s;
      dwell_r     <= dwell_nxt_s;
      y_r         <= y_nxt_s;
      y_ch_r      <= y_ch_nxt_s;
      y_valid_r   <= y_valid_nxt_s;
      scan_wrap_r <= scan_wrap_nxt_s;
    end
  end

  assign y         = y_r;
  assign y_ch      = y_ch_r;
  assign y_valid   = y_valid_r;
  assign scan_wrap = scan_wrap_r;

endmodule

// File: doc/ar_muxn_scan.md
AR_MUXN_SCAN -- requirements
Module: ar_muxn_scan

Interface
REQ-001 Parameter WIDTH, 8, bit width of each data channel (1..32).
REQ-002 Parameter CHANNELS, 4, number of input channels (2..16).
REQ-003 Parameter DWELL, 4, clock cycles spent on each channel in scan mode (1..255).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port a  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel  input  SW=max(1,clog2(CHANNELS))  manual channel select; scan start channel.
REQ-008 Port mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 Port en  input  1  output update enable; 0 freezes y, y_ch and y_valid.
REQ-010 Port hold  input  1  scan mode only: freezes pointer and dwell counter.
REQ-011 Port y  output  WIDTH  registered selected data.
REQ-012 Port y_ch  output  SW  registered index of the channel driving y.
REQ-013 Port y_valid  output  1  registered; 1 = y holds valid in-range channel data.
REQ-014 Port scan_wrap  output  1  registered one-cycle pulse when the scan pointer wraps CHANNELS-1 -> 0.

Function
REQ-015 State machine SHALL have three states: IDLE (en=0), MANUAL (en=1, mode=0), SCAN (en=1, mode=1); next state is decoded from en/mode every cycle.
REQ-016 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on y/y_ch/y_valid after edge N.
REQ-017 MANUAL: sel < CHANNELS -> y <= a[sel], y_ch <= sel, y_valid <= 1.
REQ-018 MANUAL: sel >= CHANNELS (out of range) -> y <= 0, y_ch <= sel, y_valid <= 0; no X propagation.
REQ-019 SCAN: y <= a[ptr], y_ch <= ptr, y_valid <= 1, where ptr is the internal scan pointer.
REQ-020 Dwell counter SHALL count 0..DWELL-1 in SCAN; on reaching DWELL-1 it returns to 0 and ptr advances by 1.
REQ-021 Pointer SHALL wrap from CHANNELS-1 to 0; scan_wrap SHALL be 1 for exactly the cycle after that edge, 0 otherwise.
REQ-022 Entry into SCAN from MANUAL or IDLE SHALL load ptr <= sel (ptr <= 0 if sel out of range) and clear the dwell counter; the loaded channel appears on y after the entry edge.
REQ-023 hold=1 in SCAN SHALL freeze ptr and dwell counter; y keeps tracking live a[ptr] each cycle; no scan_wrap while held.
REQ-024 hold SHALL be ignored in MANUAL and IDLE.
REQ-025 IDLE: y, y_ch, y_valid hold last values; ptr and dwell counter hold; scan_wrap = 0.
REQ-026 Returning from IDLE directly to SCAN with mode unchanged SHALL resume from the held ptr/dwell values (no reload).
REQ-027 DWELL=1 SHALL advance ptr every cycle; CHANNELS not a power of two SHALL still wrap at CHANNELS-1.
REQ-028 mode change and hold=1 in the same cycle: the entry load of REQ-022 takes priority over hold.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force y=0, y_ch=0, y_valid=0, scan_wrap=0, ptr=0, dwell counter=0, state=IDLE.
REQ-030 Reset asserted mid-scan SHALL abandon the scan; after release the first SCAN cycle reloads from sel per REQ-022.
REQ-031 Release of rst_n SHALL be synchronised by the environment; the block adds no reset synchroniser.

Verification (WIDTH=8, CHANNELS=4, DWELL=4, a = {8'h44,8'h33,8'h22,8'h11})
REQ-032 Manual: en=1, mode=0, sel=2 -> one edge later y=8'h33, y_ch=2, y_valid=1; sel=3 next cycle -> y=8'h44 one edge later.
REQ-033 Scan: en=1, mode=1, sel=1 -> y=8'h22 for 4 cycles, then 8'h33 (4), 8'h44 (4), 8'h11 with scan_wrap=1 on the first 8'h11 cycle only.
REQ-034 Hold: during scan on channel 2, hold=1 for 10 cycles, then change a[2] to 8'hA5 -> y=8'hA5 next edge, y_ch stays 2, no advance until hold=0, then remaining dwell resumes.
REQ-035 Out of range: CHANNELS=3 build, mode=0, sel=3 -> y=0, y_valid=0; mode=1 with sel=3 -> scan starts at channel 0.
REQ-036 Reset mid-scan: assert rst_n=0 between edges while y=8'h33 -> outputs 0 before next edge; release with mode=1, sel=0 -> y=8'h11 after first edge.
REQ-037 Enable: en=0 for 5 cycles during scan -> y/y_ch frozen, scan_wrap=0; en=1 -> scan resumes same channel with remaining dwell count.
